// File: rtl/wb_pwm_capture.sv
// Four-channel RC pulse-width capture with a Wishbone slave register interface.
// Optional rise-to-rise period measurement is built when PWMCAP_PERIOD_EN is defined.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   st_idle | no valid rise seen since reset/enable/timeout
//   st_high | counting high cycles of the current pulse
//   st_low  | pulse captured, waiting for the next rise
module wb_pwm_capture #(
  parameter int cnt_width      = 22,
  parameter int timeout_cycles = 5_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic        intr,
  input  logic [3:0]  pwm_in
);

  localparam int idle_w = $clog2(timeout_cycles + 1);
  localparam logic [idle_w-1:0]    tmo_load = idle_w'(timeout_cycles - 1);
  localparam logic [idle_w-1:0]    idle_one = idle_w'(1);
  localparam logic [cnt_width-1:0] cnt_one  = cnt_width'(1);
  localparam logic [cnt_width-1:0] cnt_max  = '1;

  typedef enum logic [1:0] {st_idle, st_high, st_low} chan_state_t;

  logic [3:0] sync1, sync2, sync3;
  logic [3:0] rise, fall;
  logic [3:0] new_flag, lost_flag;
  logic [3:0] cap_evt, tmo_evt;
  logic [4:0] ctrl;

  chan_state_t          state     [4];
  logic [cnt_width-1:0] width_cnt [4];
  logic [cnt_width-1:0] width_reg [4];
  logic [idle_w-1:0]    idle_cnt  [4];
`ifdef PWMCAP_PERIOD_EN
  logic [cnt_width-1:0] period_cnt [4];
  logic [cnt_width-1:0] period_reg [4];
  logic [3:0]           seen_rise;
`endif

  logic        access, wr_en;
  logic [3:0]  reg_idx;
  logic [7:0]  w1c;
  logic [31:0] rd_data;
  logic        unused_ok;

  assign unused_ok = ^{wb_sel_i, wb_adr_i[31:6], wb_adr_i[1:0], wb_dat_i[31:8]};

  assign access  = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign wr_en   = access & wb_we_i;
  assign reg_idx = wb_adr_i[5:2];
  assign w1c     = (wr_en && reg_idx == 4'd0) ? wb_dat_i[7:0] : 8'h00;

  assign rise = sync2 & ~sync3;
  assign fall = ~sync2 & sync3;
  assign intr = ctrl[4] & |new_flag;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // A rise on the terminal cycle counts as activity, so it beats the timeout.
  always_comb begin
    tmo_evt = '0;
    cap_evt = '0;
    for (int i = 0; i < 4; i++) begin
      tmo_evt[i] = ctrl[i] & ~rise[i] & (idle_cnt[i] == '0);
      cap_evt[i] = ctrl[i] & ~tmo_evt[i] & fall[i] & (state[i] == st_high);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        state[i]     <= st_idle;
        width_cnt[i] <= '0;
        width_reg[i] <= '0;
        idle_cnt[i]  <= '0;
`ifdef PWMCAP_PERIOD_EN
        period_cnt[i] <= '0;
        period_reg[i] <= '0;
        seen_rise[i]  <= 1'b0;
`endif
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!ctrl[i]) begin
          state[i]     <= st_idle;
          width_cnt[i] <= '0;
          idle_cnt[i]  <= tmo_load;
`ifdef PWMCAP_PERIOD_EN
          period_cnt[i] <= '0;
          seen_rise[i]  <= 1'b0;
`endif
        end else if (tmo_evt[i]) begin
          state[i]     <= st_idle;
          width_cnt[i] <= '0;
          width_reg[i] <= '0;
          idle_cnt[i]  <= tmo_load;
`ifdef PWMCAP_PERIOD_EN
          period_cnt[i] <= '0;
          period_reg[i] <= '0;
          seen_rise[i]  <= 1'b0;
`endif
        end else begin
          idle_cnt[i] <= rise[i] ? tmo_load : idle_cnt[i] - idle_one;
`ifdef PWMCAP_PERIOD_EN
          if (rise[i]) begin
            if (seen_rise[i]) period_reg[i] <= period_cnt[i];
            period_cnt[i] <= cnt_one;
            seen_rise[i]  <= 1'b1;
          end else if (seen_rise[i] && period_cnt[i] != cnt_max) begin
            period_cnt[i] <= period_cnt[i] + cnt_one;
          end
`endif
          case (state[i])
            st_idle, st_low: begin
              if (rise[i]) begin
                state[i]     <= st_high;
                width_cnt[i] <= cnt_one;
              end
            end
            st_high: begin
              if (fall[i]) begin
                width_reg[i] <= width_cnt[i];
                state[i]     <= st_low;
              end else if (width_cnt[i] != cnt_max) begin
                width_cnt[i] <= width_cnt[i] + cnt_one;
              end
            end
            default: state[i] <= st_idle;
          endcase
        end
      end
    end
  end

  // Hardware set wins over a same-cycle software clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      new_flag  <= '0;
      lost_flag <= '0;
    end else begin
      new_flag  <= (new_flag  & ~w1c[3:0]) | cap_evt;
      lost_flag <= (lost_flag & ~w1c[7:4]) | tmo_evt;
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_idx)
      4'd0: rd_data[7:0] = {lost_flag, new_flag};
      4'd1: rd_data[4:0] = ctrl;
      4'd2: rd_data[cnt_width-1:0] = width_reg[0];
      4'd3: rd_data[cnt_width-1:0] = width_reg[1];
      4'd4: rd_data[cnt_width-1:0] = width_reg[2];
      4'd5: rd_data[cnt_width-1:0] = width_reg[3];
`ifdef PWMCAP_PERIOD_EN
      4'd6: rd_data[cnt_width-1:0] = period_reg[0];
      4'd7: rd_data[cnt_width-1:0] = period_reg[1];
      4'd8: rd_data[cnt_width-1:0] = period_reg[2];
      4'd9: rd_data[cnt_width-1:0] = period_reg[3];
`endif
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      ctrl     <= '0;
    end else begin
      wb_ack_o <= access;
      if (access) wb_dat_o <= wb_we_i ? 32'h0 : rd_data;
      if (wr_en && reg_idx == 4'd1) ctrl <= wb_dat_i[4:0];
    end
  end

endmodule

// File: tb/tb_wb_pwm_capture.sv
// Self-checking bench for wb_pwm_capture: two instances (wide/slow-timeout and
// narrow/fast-timeout) driven with randomized pulses against a pulse-level model.
module tb_wb_pwm_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] dat_w = '0;
  logic [3:0]  sel = 4'hF;
  logic        cyc = 1'b0, stb_a = 1'b0, stb_b = 1'b0, we = 1'b0;
  logic [3:0]  pwm_in = '0;
  logic [31:0] dat_a, dat_b;
  logic        ack_a, ack_b, intr_a, intr_b;

  int passed = 0;
  int total  = 0;
  int cycle_cnt = 0;

  // model state for dut_a
  logic [7:0]  exp_status;
  int unsigned exp_width [4];

  wb_pwm_capture #(.cnt_width(16), .timeout_cycles(30000)) dut_a (
    .clk(clk), .reset(reset), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(dat_a),
    .wb_sel_i(sel), .wb_stb_i(stb_a), .wb_cyc_i(cyc), .wb_we_i(we),
    .wb_ack_o(ack_a), .intr(intr_a), .pwm_in(pwm_in));

  wb_pwm_capture #(.cnt_width(8), .timeout_cycles(1000)) dut_b (
    .clk(clk), .reset(reset), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(dat_b),
    .wb_sel_i(sel), .wb_stb_i(stb_b), .wb_cyc_i(cyc), .wb_we_i(we),
    .wb_ack_o(ack_b), .intr(intr_b), .pwm_in(pwm_in));

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  function automatic int unsigned sat(input int unsigned len, input int w);
    int unsigned mx;
    mx = (32'd1 << w) - 1;
    return (len > mx) ? mx : len;
  endfunction

  task automatic wb_xfer(input logic which, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rd);
    int n;
    @(posedge clk); #1;
    adr = a; dat_w = d; we = wr; cyc = 1'b1; stb_a = ~which; stb_b = which;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(which ? ack_b : ack_a) && n < 4);
    if (!(which ? ack_b : ack_a)) begin
      total++;
      $display("FAIL wb_ack_timeout: no ack after %0d cycles (addr %h)", n, a);
    end
    rd = which ? dat_b : dat_a;
    cyc = 1'b0; stb_a = 1'b0; stb_b = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic which, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(which, 1'b1, a, d, dummy);
  endtask

  task automatic wb_read(input logic which, input logic [31:0] a, output logic [31:0] rd);
    wb_xfer(which, 1'b0, a, 32'h0, rd);
  endtask

  task automatic pulse(input int ch, input int len);
    @(posedge clk); #1 pwm_in[ch] = 1'b1;
    repeat (len) @(posedge clk);
    #1 pwm_in[ch] = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (intr_a !== 1'b0) $display("FAIL reset_intr: got %b want 0", intr_a); else passed++;
    total++; if (ack_a !== 1'b0) $display("FAIL reset_ack: got %b want 0", ack_a); else passed++;
    total++; if (dat_b !== 32'h0) $display("FAIL reset_dat_b: got %h want 0", dat_b); else passed++;
    reset = 1'b0;
    for (int a = 0; a <= 'h14; a += 4) begin
      wb_read(1'b0, 32'(a), rd);
      total++;
      if (rd !== 32'h0) $display("FAIL reset_read[%0h]: got %h want 0", a, rd); else passed++;
    end
    exp_status = '0;
    for (int i = 0; i < 4; i++) exp_width[i] = 0;
  endtask

  task automatic test_width();
    logic [31:0] rd;
    int ch, len;
    wb_write(1'b0, 32'h04, 32'h1F);
    @(posedge clk); #1 pwm_in[0] = 1'b1;
    repeat (1500) @(posedge clk);
    #1 pwm_in[0] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    total++; if (intr_a !== 1'b0) $display("FAIL intr_early: got %b want 0", intr_a); else passed++;
    @(posedge clk); #1;
    total++; if (intr_a !== 1'b1) $display("FAIL intr_at_3: got %b want 1", intr_a); else passed++;
    exp_width[0] = 1500;
    exp_status[0] = 1'b1;
    wb_read(1'b0, 32'h08, rd);
    total++; if (rd !== 32'd1500) $display("FAIL width0_1500: got %0d want 1500", rd); else passed++;
    wb_read(1'b0, 32'h00, rd);
    total++; if (rd !== 32'h01) $display("FAIL status_after_ch0: got %h want 01", rd); else passed++;
    for (int k = 0; k < 4; k++) begin
      ch  = $urandom_range(0, 3);
      len = $urandom_range(2, 1800);
      repeat ($urandom_range(3, 40)) @(posedge clk);
      pulse(ch, len);
      repeat (4) @(posedge clk);
      exp_width[ch] = sat(len, 16);
      exp_status[ch] = 1'b1;
      wb_read(1'b0, 32'(8 + 4 * ch), rd);
      total++;
      if (rd !== 32'(exp_width[ch])) $display("FAIL width_rand ch%0d: got %0d want %0d", ch, rd, exp_width[ch]);
      else passed++;
      wb_read(1'b0, 32'h00, rd);
      total++;
      if (rd !== {24'h0, exp_status}) $display("FAIL status_rand: got %h want %h", rd, exp_status);
      else passed++;
    end
  endtask

  task automatic test_w1c();
    logic [31:0] rd;
    wb_write(1'b0, 32'h00, {24'h0, exp_status});
    exp_status = '0;
    total++; if (intr_a !== 1'b0) $display("FAIL w1c_intr: got %b want 0", intr_a); else passed++;
    wb_read(1'b0, 32'h00, rd);
    total++; if (rd !== 32'h0) $display("FAIL w1c_status: got %h want 0", rd); else passed++;
    pulse(1, 100);
    repeat (4) @(posedge clk);
    // second capture lands on the very edge that performs the W1C of bit 1
    @(posedge clk); #1 pwm_in[1] = 1'b1;
    repeat (200) @(posedge clk);
    #1 pwm_in[1] = 1'b0;
    @(posedge clk);
    wb_write(1'b0, 32'h00, 32'h02);
    exp_status[1] = 1'b1;
    exp_width[1] = 200;
    wb_read(1'b0, 32'h00, rd);
    total++; if (rd !== {24'h0, exp_status}) $display("FAIL set_wins: got %h want %h", rd, exp_status); else passed++;
    wb_read(1'b0, 32'h0C, rd);
    total++; if (rd !== 32'd200) $display("FAIL width1_latest: got %0d want 200", rd); else passed++;
    wb_write(1'b0, 32'h28, 32'hFFFF_FFFF);
    wb_read(1'b0, 32'h28, rd);
    total++; if (rd !== 32'h0) $display("FAIL unmapped_read: got %h want 0", rd); else passed++;
    wb_read(1'b0, 32'h04, rd);
    total++; if (rd !== 32'h1F) $display("FAIL ctrl_readback: got %h want 1F", rd); else passed++;
    wb_write(1'b0, 32'h04, 32'h0);
    wb_write(1'b0, 32'h00, 32'hFF);
    exp_status = '0;
  endtask

  task automatic test_disable_mid_pulse();
    logic [31:0] rd;
    wb_write(1'b0, 32'h04, 32'h01);
    @(posedge clk); #1 pwm_in[0] = 1'b1;
    repeat (30) @(posedge clk);
    wb_write(1'b0, 32'h04, 32'h00);
    repeat (10) @(posedge clk);
    #1 pwm_in[0] = 1'b0;
    repeat (5) @(posedge clk);
    wb_read(1'b0, 32'h00, rd);
    total++; if (rd !== 32'h0) $display("FAIL disable_status: got %h want 0", rd); else passed++;
    wb_read(1'b0, 32'h08, rd);
    total++; if (rd !== 32'(exp_width[0])) $display("FAIL disable_width0: got %0d want %0d", rd, exp_width[0]); else passed++;
  endtask

  task automatic test_back_to_back();
    wb_write(1'b0, 32'h04, 32'h05);
    @(posedge clk); #1;
    adr = 32'h04; we = 1'b0; cyc = 1'b1; stb_a = 1'b1;
    @(posedge clk); #1;
    total++; if (ack_a !== 1'b1 || dat_a !== 32'h05) $display("FAIL b2b_first: ack %b dat %h want 1/05", ack_a, dat_a); else passed++;
    @(posedge clk); #1;
    total++; if (ack_a !== 1'b0) $display("FAIL b2b_gap: ack %b want 0", ack_a); else passed++;
    @(posedge clk); #1;
    total++; if (ack_a !== 1'b1 || dat_a !== 32'h05) $display("FAIL b2b_second: ack %b dat %h want 1/05", ack_a, dat_a); else passed++;
    cyc = 1'b0; stb_a = 1'b0;
    @(posedge clk); #1;
    total++; if (ack_a !== 1'b0) $display("FAIL b2b_end: ack %b want 0", ack_a); else passed++;
    wb_write(1'b0, 32'h04, 32'h00);
  endtask

  task automatic test_timeout();
    logic [31:0] rd;
    int t0;
    wb_write(1'b1, 32'h04, 32'h06);
    t0 = cycle_cnt;
    pulse(2, 50);
    while (cycle_cnt < t0 + 985) @(posedge clk);
    wb_read(1'b1, 32'h00, rd);
    total++; if (rd !== 32'h04) $display("FAIL pre_timeout_status: got %h want 04", rd); else passed++;
    wb_read(1'b1, 32'h10, rd);
    total++; if (rd !== 32'd50) $display("FAIL pre_timeout_width2: got %0d want 50", rd); else passed++;
    while (cycle_cnt < t0 + 1040) @(posedge clk);
    wb_read(1'b1, 32'h00, rd);
    total++; if (rd !== 32'h64) $display("FAIL timeout_status: got %h want 64", rd); else passed++;
    wb_read(1'b1, 32'h10, rd);
    total++; if (rd !== 32'h0) $display("FAIL timeout_width2: got %0d want 0", rd); else passed++;
    wb_write(1'b1, 32'h04, 32'h00);
    wb_write(1'b1, 32'h00, 32'hFF);
  endtask

  task automatic test_saturation();
    logic [31:0] rd;
    int unsigned last;
    int len;
    wb_write(1'b1, 32'h04, 32'h08);
    pulse(3, 300);
    repeat (4) @(posedge clk);
    last = sat(300, 8);
    wb_read(1'b1, 32'h14, rd);
    total++; if (rd !== 32'(last)) $display("FAIL sat_width3: got %0d want %0d", rd, last); else passed++;
    wb_read(1'b1, 32'h00, rd);
    total++; if (rd !== 32'h08) $display("FAIL sat_status: got %h want 08", rd); else passed++;
    for (int k = 0; k < 3; k++) begin
      len = $urandom_range(2, 600);
      pulse(3, len);
      repeat (4) @(posedge clk);
      last = sat(len, 8);
      wb_read(1'b1, 32'h14, rd);
      total++; if (rd !== 32'(last)) $display("FAIL sat_rand len %0d: got %0d want %0d", len, rd, last); else passed++;
    end
    wb_write(1'b1, 32'h04, 32'h00);
    wb_write(1'b1, 32'h00, 32'hFF);
    pulse(3, 40);
    repeat (4) @(posedge clk);
    wb_read(1'b1, 32'h00, rd);
    total++; if (rd !== 32'h0) $display("FAIL disabled_status: got %h want 0", rd); else passed++;
    wb_read(1'b1, 32'h14, rd);
    total++; if (rd !== 32'(last)) $display("FAIL disabled_width3: got %0d want %0d", rd, last); else passed++;
  endtask

  task automatic test_period();
    logic [31:0] rd;
`ifdef PWMCAP_PERIOD_EN
    int t;
    wb_write(1'b0, 32'h04, 32'h01);
    @(posedge clk); #1 pwm_in[0] = 1'b1;
    t = cycle_cnt;
    repeat (10) @(posedge clk);
    #1 pwm_in[0] = 1'b0;
    while (cycle_cnt < t + 20000) @(posedge clk);
    #1 pwm_in[0] = 1'b1;
    repeat (10) @(posedge clk);
    #1 pwm_in[0] = 1'b0;
    repeat (5) @(posedge clk);
    exp_width[0] = 10;
    wb_read(1'b0, 32'h18, rd);
    total++; if (rd !== 32'd20000) $display("FAIL period0: got %0d want 20000", rd); else passed++;
    wb_write(1'b0, 32'h04, 32'h00);
    wb_write(1'b0, 32'h00, 32'hFF);
`else
    wb_read(1'b0, 32'h18, rd);
    total++; if (rd !== 32'h0) $display("FAIL period_unmapped: got %h want 0", rd); else passed++;
`endif
  endtask

  task automatic test_reset_mid_pulse();
    logic [31:0] rd;
    wb_write(1'b0, 32'h04, 32'h01);
    @(posedge clk); #1 pwm_in[0] = 1'b1;
    repeat (40) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_status = '0;
    for (int i = 0; i < 4; i++) exp_width[i] = 0;
    repeat (6) @(posedge clk);
    wb_write(1'b0, 32'h04, 32'h01);
    repeat (10) @(posedge clk);
    #1 pwm_in[0] = 1'b0;
    repeat (5) @(posedge clk);
    wb_read(1'b0, 32'h00, rd);
    total++; if (rd !== 32'h0) $display("FAIL rst_mid_status: got %h want 0", rd); else passed++;
    wb_read(1'b0, 32'h08, rd);
    total++; if (rd !== 32'(exp_width[0])) $display("FAIL rst_mid_width0: got %0d want %0d", rd, exp_width[0]); else passed++;
  endtask

  initial begin
    test_reset();
    test_width();
    test_w1c();
    test_disable_mid_pulse();
    test_back_to_back();
    test_timeout();
    test_saturation();
    test_period();
    test_reset_mid_pulse();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
